// File: rtl/conv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_mem_pkg
// Description : Bank-select encoding, bank map and helpers shared by the
//               CONV result-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_mem_pkg;

  // Bank select encoding shared by csel and dbg_sel
  localparam logic [2:0] SEL_L0K0 = 3'd1;
  localparam logic [2:0] SEL_L0K1 = 3'd2;
  localparam logic [2:0] SEL_L1K0 = 3'd3;
  localparam logic [2:0] SEL_L1K1 = 3'd4;
  localparam logic [2:0] SEL_L2   = 3'd5;

  // Flat storage layout
  localparam int          TOTAL_DEPTH = 12288;
  localparam int          FLAT_AW     = 14;
  localparam logic [13:0] BASE_L0K0   = 14'd0;
  localparam logic [13:0] BASE_L0K1   = 14'd4096;
  localparam logic [13:0] BASE_L1K0   = 14'd8192;
  localparam logic [13:0] BASE_L1K1   = 14'd9216;
  localparam logic [13:0] BASE_L2     = 14'd10240;
  localparam logic [31:0] DEPTH_L0    = 32'd4096;
  localparam logic [31:0] DEPTH_L1    = 32'd1024;
  localparam logic [31:0] DEPTH_L2    = 32'd2048;

  localparam logic [13:0] WR_CNT_MAX  = 14'h3FFF;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic        legal;
    logic [13:0] flat;
  } bank_map_t;

  // Translate a bank-relative access to a flat address and legality flag.
  // An unused select gets depth 0, so every address on it is illegal.
  function automatic bank_map_t map_access(input logic [2:0] sel, input logic [31:0] addr);
    logic [13:0] base;
    logic [31:0] depth;
    bank_map_t   m;
    base  = '0;
    depth = '0;
    case (sel)
      SEL_L0K0: begin base = BASE_L0K0; depth = DEPTH_L0; end
      SEL_L0K1: begin base = BASE_L0K1; depth = DEPTH_L0; end
      SEL_L1K0: begin base = BASE_L1K0; depth = DEPTH_L1; end
      SEL_L1K1: begin base = BASE_L1K1; depth = DEPTH_L1; end
      SEL_L2:   begin base = BASE_L2;   depth = DEPTH_L2; end
      default:  begin base = '0;        depth = '0;       end
    endcase
    m.legal = (addr < depth);
    m.flat  = base + addr[13:0];
    return m;
  endfunction

  // Layer flag raised by a write to the given bank
  function automatic logic [2:0] layer_flag(input logic [2:0] sel);
    logic [2:0] f;
    case (sel)
      SEL_L0K0, SEL_L0K1: f = 3'b001;
      SEL_L1K0, SEL_L1K1: f = 3'b010;
      SEL_L2:             f = 3'b100;
      default:            f = 3'b000;
    endcase
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_mem_dpram.sv
`default_nettype none
// ============================================================================
// Module      : conv_mem_dpram
// Description : Simple dual-port RAM, one write port and one registered read
//               port, no reset. Read-first on a same-address collision.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_mem_dpram #(
  parameter int DW     = 20,
  parameter int DEPTH  = 12288,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DW-1:0]     wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  output logic [DW-1:0]     rd_data
);

  logic [DW-1:0] r_mem [DEPTH];

  // Write and registered read share one block so a collision returns the old word
  always_ff @(posedge clk) begin
    if (we) r_mem[wa] <= wd;
    if (re) rd_data <= r_mem[ra];
  end

endmodule
`default_nettype wire

// File: rtl/conv_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : conv_mem_resp
// Description : CONV result-memory responder: L0/L1/L2 banks in one flat RAM,
//               legality checking, debug read arbiter, flags and counters.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_mem_resp
  import conv_mem_pkg::*;
#(
  parameter int DW = 20,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          busy,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  input  logic [2:0]    csel,
  output logic [DW-1:0] cdata_rd,
  input  logic          dbg_rd,
  input  logic [2:0]    dbg_sel,
  input  logic [AW-1:0] dbg_addr,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_data,
  output logic [2:0]    check,
  output logic          err,
  output logic [13:0]   wr_cnt,
  output logic          done
);

  bank_map_t     w_wr_map;
  bank_map_t     w_rd_map;
  bank_map_t     w_dbg_map;
  logic          w_dbg_issue;
  logic          w_ram_we;
  logic          w_ram_re;
  logic [13:0]   w_ram_ra;
  logic [DW-1:0] w_ram_q;

  arb_state_t    r_state;
  logic          r_dbg_legal;
  logic          r_conv_fresh;
  logic          r_conv_legal;
  logic [DW-1:0] r_cdata_hold;
  logic          r_busy_q;

  assign w_wr_map  = map_access(csel, 32'(caddr_wr));
  assign w_rd_map  = map_access(csel, 32'(caddr_rd));
  assign w_dbg_map = map_access(dbg_sel, 32'(dbg_addr));

  // The single read port goes to the CONV engine whenever crd is high;
  // the debug side only gets it on an otherwise idle cycle.
  assign w_dbg_issue = (r_state == ARB_IDLE) && dbg_rd && !crd;
  assign w_ram_we    = cwr && w_wr_map.legal;
  assign w_ram_re    = (crd && w_rd_map.legal) || (w_dbg_issue && w_dbg_map.legal);
  assign w_ram_ra    = crd ? w_rd_map.flat : w_dbg_map.flat;

  conv_mem_dpram #(
    .DW     (DW),
    .DEPTH  (TOTAL_DEPTH),
    .ADDR_W (FLAT_AW)
  ) u_ram (
    .clk     (clk),
    .we      (w_ram_we),
    .wa      (w_wr_map.flat),
    .wd      (cdata_wr),
    .re      (w_ram_re),
    .ra      (w_ram_ra),
    .rd_data (w_ram_q)
  );

  // cdata_rd shows the RAM word the cycle after a CONV read and otherwise
  // replays its held copy, so debug reads through the shared port never disturb it.
  assign cdata_rd = r_conv_fresh ? (r_conv_legal ? w_ram_q : '0) : r_cdata_hold;

  // Track CONV read issue and keep a copy of the presented read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_conv_fresh <= 1'b0;
      r_conv_legal <= 1'b0;
      r_cdata_hold <= '0;
    end else begin
      r_conv_fresh <= crd;
      r_conv_legal <= w_rd_map.legal;
      r_cdata_hold <= cdata_rd;
    end
  end

  // Sticky layer flags, sticky error and saturating write counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      check  <= '0;
      err    <= 1'b0;
      wr_cnt <= '0;
    end else begin
      if (w_ram_we) begin
        check <= check | layer_flag(csel);
        if (wr_cnt != WR_CNT_MAX) wr_cnt <= wr_cnt + 14'd1;
      end
      if ((cwr && !w_wr_map.legal) || (crd && !w_rd_map.legal)) err <= 1'b1;
    end
  end

  // Debug arbiter: issue on an idle read port, acknowledge one cycle later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ARB_IDLE;
      r_dbg_legal <= 1'b0;
      dbg_ack     <= 1'b0;
      dbg_data    <= '0;
    end else begin
      dbg_ack <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_dbg_issue) begin
            r_state     <= ARB_WAIT;
            r_dbg_legal <= w_dbg_map.legal;
          end
        end
        ARB_WAIT: begin
          r_state  <= ARB_IDLE;
          dbg_ack  <= 1'b1;
          dbg_data <= r_dbg_legal ? w_ram_q : '0;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  // Previous busy for end-of-run edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_busy_q <= 1'b0;
    else        r_busy_q <= busy;
  end

  assign done = r_busy_q && !busy;

endmodule
`default_nettype wire

// File: doc/conv_mem_resp.md
# conv_mem_resp

Synthesizable responder for the CONV result-memory port (`cwr`/`crd`/`csel`/`caddr_*`/`cdata_*`). It holds the layer-0, layer-1 and layer-2 result banks that the CONV engine writes and reads back. It sits opposite the CONV engine in FPGA and emulation builds, replacing the behavioural bank models used in simulation. A secondary debug read port lets a host or checker drain the banks after `busy` falls.

## Interface
- `DW`, default 20: data width of every bank word.
- `AW`, default 12: address width of `caddr_wr`, `caddr_rd` and `dbg_addr`.
- `clk  in  1`: single clock; all logic on the rising edge.
- `reset  in  1`: asynchronous, active-low reset.
- `busy  in  DW?no, 1`: CONV busy flag, used only for end-of-run detection.
- `cwr  in  1`: write strobe.
- `caddr_wr  in  AW`: write address.
- `cdata_wr  in  DW`: write data.
- `crd  in  1`: read strobe.
- `caddr_rd  in  AW`: read address.
- `csel  in  3`: bank select. 1 = L0_K0, 2 = L0_K1, 3 = L1_K0, 4 = L1_K1, 5 = L2.
- `cdata_rd  out  DW`: registered read data.
- `dbg_rd  in  1`: debug read request, level-held until `dbg_ack`.
- `dbg_sel  in  3`: debug bank select, same encoding as `csel`.
- `dbg_addr  in  AW`: debug address.
- `dbg_ack  out  1`: one-cycle pulse; `dbg_data` is valid in the same cycle.
- `dbg_data  out  DW`: debug read data.
- `check  out  3`: sticky flags. Bit 0 = any L0 write, bit 1 = any L1 write, bit 2 = any L2 write.
- `err  out  1`: sticky flag for an illegal access.
- `wr_cnt  out  14`: saturating count of accepted writes.
- `done  out  1`: one-cycle pulse on the falling edge of `busy`.

## Operation
- **Flat storage:** 12288 × DW words, one write port and one read port.
- **Bank bases and depths:**
  - csel 1: base 0, depth 4096.
  - csel 2: base 4096, depth 4096.
  - csel 3: base 8192, depth 1024.
  - csel 4: base 9216, depth 1024.
  - csel 5: base 10240, depth 2048.
- **Address mapping:** flat address = base + address (14-bit result).
- **Write:** when `cwr`=1 and the access is legal, the word is stored at the posedge. The matching `check` bit is set and `wr_cnt` increments, saturating at 16383.
- **Read:** when `crd`=1 and the access is legal, `cdata_rd` is loaded at the posedge from the addressed word. When `crd`=0, `cdata_rd` holds its value.
- **Illegal access:** `csel` of 0, 6 or 7, or an address ≥ the bank depth.
  - Illegal writes are dropped.
  - Illegal reads load 0 into `cdata_rd`.
  - Either case sets `err`.
- **Shared select:** `cwr` and `crd` share `csel`, so a simultaneous read and write always target the same bank.
- **Read-during-write to the same flat address:** read-first; `cdata_rd` gets the old word.
- **Debug arbiter, two states:**
  - IDLE → WAIT when `dbg_rd`=1 and `crd`=0. The read port is issued with `dbg_sel`/`dbg_addr`.
  - WAIT → IDLE on the next cycle, pulsing `dbg_ack`.
  - `crd` always has priority. While `crd`=1 the arbiter stays in IDLE and stalls with no ack.
  - An illegal debug access returns 0 with `dbg_ack`. It does not set `err`.
- **End of run:** `busy` is registered once. `done` = previous `busy` & ~`busy`.

## Timing
- Write latency: 1 cycle; the word is readable on the next posedge.
- CONV read latency: 1 cycle; `cdata_rd` is valid the cycle after `crd` is sampled.
- Debug read latency: 2 cycles minimum from `dbg_rd` to `dbg_ack`, plus any stall cycles while `crd`=1.
- Reset values: `cdata_rd`=0, `dbg_data`=0, `dbg_ack`=0, `check`=0, `err`=0, `wr_cnt`=0, `done`=0, arbiter in IDLE.
- Storage is not reset; contents survive `reset`.
- Reset asserted mid-operation: all outputs clear immediately (asynchronously). An in-flight debug read is discarded with no ack. A write in the same cycle as the reset assertion is not guaranteed.

## Structure
- Package `conv_mem_pkg` holds:
  - the `csel` encoding constants (`SEL_L0K0` … `SEL_L2`);
  - bank base and depth constants;
  - the total depth, 12288.
- Sub-module `conv_mem_dpram`: a simple dual-port RAM (one write port, one registered read port) with no reset. It infers block RAM.
- The top level contains address decode, legality check, arbiter, flags and counter.

## Test plan
- Reset with `reset`=0, then release → all outputs 0. Write 20'hABCDE at csel=1, addr 0 → `check`=3'b001, `wr_cnt`=1.
- Write 20'h12345 at csel=3, addr 1023; then `crd` at the same csel/addr → `cdata_rd`=20'h12345 exactly one cycle later. `check`=3'b010 (with no prior L0 write).
- Write at csel=4, addr 1024, and read at csel=6 → write dropped, `cdata_rd`=0, `err`=1, `wr_cnt` unchanged.
- Same-cycle `cwr` and `crd` to csel=5, addr 7: old word 20'h00001, new word 20'h00002 → `cdata_rd`=20'h00001. The next read returns 20'h00002.
- `dbg_rd` on csel=2, addr 4095 while `crd` is held high for 3 cycles → no ack during the stall. `dbg_ack` pulses 2 cycles after `crd` drops, with the correct `dbg_data`.
- Drive `busy` 1→0 → `done` pulses for exactly one cycle. Assert `reset` mid-stream, then deassert → flags clear, and a debug read at a previously written address returns the retained data.
